// File: rtl/multi_key_led_ctrl.sv
// N-channel push-button front end: per-key 2-flop synchroniser, debounce and press
// detection, driving N LEDs in toggle, momentary or radio (one-hot group) mode.
module multi_key_led_ctrl #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LED_ACTIVE_LOW  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] key_i,
  input  logic [1:0]        mode_i,
  input  logic              clr_i,
  output logic [N_KEYS-1:0] led_o,
  output logic [N_KEYS-1:0] led_state_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] key_db_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'b00,
    MODE_MOMENTARY = 2'b01,
    MODE_RADIO     = 2'b10,
    MODE_RSVD      = 2'b11
  } mode_e;

  mode_e mode;
  assign mode = mode_e'(mode_i);

  // One-hot of the lowest set bit; used so simultaneous radio presses resolve to lowest index.
  function automatic logic [N_KEYS-1:0] lowest_onehot(input logic [N_KEYS-1:0] v);
    logic [N_KEYS-1:0] r;
    logic              found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  logic [N_KEYS-1:0] s1_q, s2_q;
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [N_KEYS-1:0] db_q, db_d;
  logic [N_KEYS-1:0] db_prev_q;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] led_q, led_d;
  logic [N_KEYS-1:0] radio_sel;

  // Stage 0/1: synchroniser, released (high) out of reset so a held key is seen as a new press
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= key_i;
      s2_q <= s1_q;
    end
  end

  // Stage 2: debounce; db holds the pressed level (1 = pressed)
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (~s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = ~s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) cnt_q[i] <= cnt_d[i];
      db_q      <= db_d;
      db_prev_q <= db_q;
    end
  end

  // Stage 3: press detection and LED state update share the same edge
  assign press_d   = db_q & ~db_prev_q;
  assign radio_sel = lowest_onehot(press_d);

  always_comb begin
    led_d = led_q;
    if (clr_i) begin
      led_d = '0;
    end else begin
      case (mode)
        MODE_MOMENTARY: led_d = db_d;
        MODE_RADIO: begin
          if (|press_d) led_d = (led_q == radio_sel) ? '0 : radio_sel;
        end
        default: led_d = led_q ^ press_d;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      press_q <= '0;
      led_q   <= '0;
    end else begin
      press_q <= press_d;
      led_q   <= led_d;
    end
  end

  assign led_o       = (LED_ACTIVE_LOW != 0) ? ~led_q : led_q;
  assign led_state_o = led_q;
  assign press_o     = press_q;
  assign key_db_o    = db_q;

endmodule

// File: tb/tb_multi_key_led_ctrl.sv
// Directed bench for multi_key_led_ctrl with 4 keys, 4-cycle debounce, active-low LEDs.
module tb_multi_key_led_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic [1:0] mode;
  logic       clr;
  logic [3:0] led, led_state, press, key_db;

  int n_chk  = 0;
  int n_fail = 0;
  int pcnt [4];
  int snap;

  multi_key_led_ctrl #(
    .N_KEYS(4),
    .DEBOUNCE_CYCLES(4),
    .LED_ACTIVE_LOW(1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .key_i      (key),
    .mode_i     (mode),
    .clr_i      (clr),
    .led_o      (led),
    .led_state_o(led_state),
    .press_o    (press),
    .key_db_o   (key_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 4; i++) pcnt[i] = 0;
  always @(negedge clk) begin
    for (int j = 0; j < 4; j++) if (press[j] === 1'b1) pcnt[j] = pcnt[j] + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full press: 7 cycles low registers the press, then release and let it settle.
  task automatic do_press(input logic [3:0] mask);
    key = key & ~mask;
    tick(7);
    key = key | mask;
    tick(8);
  endtask

  initial begin
    rst  = 1'b1;
    key  = 4'b1111;
    mode = 2'b00;
    clr  = 1'b0;
    tick(3);
    // 1: reset state
    check_eq("rst_led", led, 4'b1111);
    check_eq("rst_state", led_state, 4'b0000);
    check_eq("rst_press", press, 4'b0000);
    check_eq("rst_keydb", key_db, 4'b0000);
    rst = 1'b0;
    tick(3);
    check_eq("post_rst_led", led, 4'b1111);

    // 2: toggle, held key gives exactly one press at edge 6
    key[0] = 1'b0;
    tick(6);
    check_eq("tg_db_e5", key_db, 4'b0001);
    check_eq("tg_press_e5", press, 4'b0000);
    check_eq("tg_state_e5", led_state, 4'b0000);
    tick(1);
    check_eq("tg_press_e6", press, 4'b0001);
    check_eq("tg_led_e6", led, 4'b1110);
    tick(1);
    check_eq("tg_press_e7", press, 4'b0000);
    tick(12);
    key[0] = 1'b1;
    tick(8);
    check_eq("tg_hold_count", pcnt[0], 1);
    check_eq("tg_rel_db", key_db, 4'b0000);
    check_eq("tg_rel_led", led, 4'b1110);
    do_press(4'b0001);
    check_eq("tg_second_led", led, 4'b1111);
    check_eq("tg_second_count", pcnt[0], 2);

    // 3: bounce on key 1 never reaches four stable samples
    snap = pcnt[1];
    key[1] = 1'b0; tick(3);
    key[1] = 1'b1; tick(1);
    key[1] = 1'b0; tick(3);
    key[1] = 1'b1; tick(8);
    check_eq("bn_db", key_db, 4'b0000);
    check_eq("bn_count", pcnt[1], snap);
    do_press(4'b0010);
    check_eq("bn_good_count", pcnt[1], snap + 1);
    check_eq("bn_state", led_state, 4'b0010);

    // 4: radio
    mode = 2'b10;
    tick(1);
    check_eq("rd_entry_keep", led_state, 4'b0010);
    do_press(4'b0100);
    check_eq("rd_k2", led_state, 4'b0100);
    do_press(4'b0001);
    check_eq("rd_k0", led_state, 4'b0001);
    do_press(4'b0001);
    check_eq("rd_k0_off", led_state, 4'b0000);
    do_press(4'b1010);
    check_eq("rd_k1k3", led_state, 4'b0010);

    // 5: momentary
    mode = 2'b01;
    tick(1);
    check_eq("mo_entry", led_state, 4'b0000);
    key[3] = 1'b0;
    tick(5);
    check_eq("mo_e4", led_state, 4'b0000);
    tick(1);
    check_eq("mo_e5", led_state, 4'b1000);
    tick(1);
    check_eq("mo_press", press, 4'b1000);
    tick(5);
    key[3] = 1'b1;
    tick(5);
    check_eq("mo_rel_e4", led_state, 4'b1000);
    tick(1);
    check_eq("mo_rel_e5", led_state, 4'b0000);
    key[3] = 1'b0;
    tick(8);
    mode = 2'b00;
    tick(3);
    check_eq("mo_leave", led_state, 4'b1000);
    key[3] = 1'b1;
    tick(8);
    check_eq("mo_leave_rel", led_state, 4'b1000);

    // 6: reset mid-debounce, key held through reset, clear with a press
    do_press(4'b1000);
    check_eq("tg_clean", led_state, 4'b0000);
    snap = pcnt[2];
    key[2] = 1'b0;
    tick(4);
    rst = 1'b1;
    key[2] = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    check_eq("rmd_count", pcnt[2], snap);
    check_eq("rmd_db", key_db, 4'b0000);
    key[2] = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    check_eq("hold_rst_e5", press, 4'b0000);
    tick(1);
    check_eq("hold_rst_e6", press, 4'b0100);
    check_eq("hold_rst_state", led_state, 4'b0100);
    key[2] = 1'b1;
    tick(8);
    do_press(4'b0100);
    do_press(4'b1011);
    check_eq("clr_pre", led_state, 4'b1011);
    key[1] = 1'b0;
    tick(6);
    clr = 1'b1;
    tick(1);
    check_eq("clr_state", led_state, 4'b0000);
    check_eq("clr_press", press, 4'b0010);
    check_eq("clr_led", led, 4'b1111);
    clr = 1'b0;
    key[1] = 1'b1;
    tick(8);

    // reserved mode behaves as toggle
    mode = 2'b11;
    do_press(4'b0001);
    check_eq("rsvd_toggle", led_state, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
